// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch vs. load/store) in front of a single-outstanding memory controller.
// LSB has priority, a streak counter bounds fetch starvation, and flushes suppress stale completions.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic        ls_signed,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        mc_valid,
  output logic        mc_we,
  output logic [1:0]  mc_size,
  output logic        mc_signed,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  input  logic        mc_ready,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
);

  localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_e;

  state_e              state_q;
  owner_e              owner_q;
  logic [STREAK_W-1:0] streak_q;
  logic                discard_q;
  logic                if_done_q, ls_done_q;
  logic [31:0]         if_data_q, ls_rdata_q;
  logic                mc_valid_q, mc_we_q, mc_signed_q;
  logic [1:0]          mc_size_q;
  logic [31:0]         mc_addr_q, mc_wdata_q;

  logic if_ok, starved, ls_win, if_win, flushable, complete;

  // A flushed cycle hides the fetch request entirely, including from the starvation guard.
  assign if_ok     = if_req && !flush;
  assign starved   = (streak_q == STREAK_W'(STARVE_LIMIT));
  assign ls_win    = ls_req && !(starved && if_ok);
  assign if_win    = if_ok && !ls_win;
  // Stores are already committed, so only fetches and loads can be discarded.
  assign flushable = flush && ((owner_q == OWN_IF) || ((owner_q == OWN_LS) && !mc_we_q));
  assign complete  = ((state_q == S_ISSUE) && mc_ready && mc_done) ||
                     ((state_q == S_WAIT) && mc_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      streak_q    <= '0;
      discard_q   <= 1'b0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      if_data_q   <= '0;
      ls_rdata_q  <= '0;
      mc_valid_q  <= 1'b0;
      mc_we_q     <= 1'b0;
      mc_size_q   <= '0;
      mc_signed_q <= 1'b0;
      mc_addr_q   <= '0;
      mc_wdata_q  <= '0;
    end else if (rdy) begin
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      if (flushable) discard_q <= 1'b1;

      // Done pulse is registered on the completion edge so it appears the cycle after mc_done.
      if (complete) begin
        state_q <= S_RESP;
        if (owner_q == OWN_IF) begin
          if_data_q <= mc_rdata;
          if_done_q <= !(discard_q || flushable);
        end else begin
          ls_rdata_q <= mc_rdata;
          ls_done_q  <= !(discard_q || flushable);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (ls_win) begin
            state_q     <= S_ISSUE;
            owner_q     <= OWN_LS;
            mc_valid_q  <= 1'b1;
            mc_we_q     <= ls_we;
            mc_size_q   <= ls_size;
            mc_signed_q <= ls_signed;
            mc_addr_q   <= ls_addr;
            mc_wdata_q  <= ls_wdata;
            if (!if_ok)        streak_q <= '0;
            else if (!starved) streak_q <= streak_q + STREAK_W'(1);
          end else if (if_win) begin
            state_q     <= S_ISSUE;
            owner_q     <= OWN_IF;
            mc_valid_q  <= 1'b1;
            mc_we_q     <= 1'b0;
            mc_size_q   <= 2'd2;
            mc_signed_q <= 1'b0;
            mc_addr_q   <= if_addr;
            mc_wdata_q  <= '0;
            streak_q    <= '0;
          end
        end
        S_ISSUE: begin
          if (mc_ready) begin
            mc_valid_q <= 1'b0;
            if (!mc_done) state_q <= S_WAIT;
          end
        end
        S_WAIT: ;
        S_RESP: begin
          discard_q <= 1'b0;
          owner_q   <= OWN_NONE;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign ls_done   = ls_done_q;
  assign ls_rdata  = ls_rdata_q;
  assign mc_valid  = mc_valid_q;
  assign mc_we     = mc_we_q;
  assign mc_size   = mc_size_q;
  assign mc_signed = mc_signed_q;
  assign mc_addr   = mc_addr_q;
  assign mc_wdata  = mc_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the controller side is driven by hand, expectations are fixed constants.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req, ls_we, ls_signed;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        mc_valid, mc_we, mc_signed;
  logic [1:0]  mc_size;
  logic [31:0] mc_addr, mc_wdata;
  logic        mc_ready, mc_done;
  logic [31:0] mc_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] starve_addr [6];
  logic        starve_is_ls [6];

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_signed(ls_signed),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mc_valid(mc_valid), .mc_we(mc_we), .mc_size(mc_size), .mc_signed(mc_signed),
    .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_ready(mc_ready), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Controller accepts, then finishes one cycle later; leaves the arbiter in RESP.
  task automatic xfer(input logic [31:0] data);
    mc_ready = 1'b1;
    tick();
    mc_ready = 1'b0;
    mc_done  = 1'b1;
    mc_rdata = data;
    tick();
    mc_done  = 1'b0;
  endtask

  initial begin
    starve_addr  = '{32'h3000, 32'h3000, 32'h3000, 32'h3000, 32'h200, 32'h3000};
    starve_is_ls = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = '0; ls_signed = 1'b0; ls_addr = '0; ls_wdata = '0;
    mc_ready = 1'b0; mc_done = 1'b0; mc_rdata = '0;
    tick(); tick();
    chk("rst_mc_valid", 32'(mc_valid), 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_ls_done", 32'(ls_done), 32'd0);
    chk("rst_mc_addr", mc_addr, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_no_req", 32'(mc_valid), 32'd0);

    // Plain fetch
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    chk("f_valid", 32'(mc_valid), 32'd1);
    chk("f_addr", mc_addr, 32'h100);
    chk("f_size", 32'(mc_size), 32'd2);
    chk("f_we", 32'(mc_we), 32'd0);
    mc_ready = 1'b1;
    tick();
    chk("f_valid_drop", 32'(mc_valid), 32'd0);
    mc_ready = 1'b0; mc_done = 1'b1; mc_rdata = 32'h00A00513;
    tick();
    mc_done = 1'b0;
    chk("f_done", 32'(if_done), 32'd1);
    chk("f_data", if_data, 32'h00A00513);
    if_req = 1'b0;
    tick();
    chk("f_done_once", 32'(if_done), 32'd0);

    // Simultaneous requests: LSB first
    if_req = 1'b1; if_addr = 32'h104;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_signed = 1'b1; ls_addr = 32'h2000;
    tick();
    chk("pri_addr", mc_addr, 32'h2000);
    chk("pri_size", 32'(mc_size), 32'd0);
    chk("pri_signed", 32'(mc_signed), 32'd1);
    xfer(32'hFFFFFF80);
    chk("pri_ls_done", 32'(ls_done), 32'd1);
    chk("pri_ls_rdata", ls_rdata, 32'hFFFFFF80);
    chk("pri_if_idle", 32'(if_done), 32'd0);
    ls_req = 1'b0;
    tick(); tick();
    chk("pri_f_addr", mc_addr, 32'h104);
    chk("pri_f_size", 32'(mc_size), 32'd2);
    xfer(32'h11111111);
    chk("pri_f_done", 32'(if_done), 32'd1);
    chk("pri_f_data", if_data, 32'h11111111);
    if_req = 1'b0;
    tick();

    // Starvation guard: four LSB grants, one fetch, then LSB again
    if_req = 1'b1; if_addr = 32'h200;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_signed = 1'b0; ls_addr = 32'h3000;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("stv_addr%0d", i), mc_addr, starve_addr[i]);
      xfer(32'hA0 + 32'(i));
      chk($sformatf("stv_ls_done%0d", i), 32'(ls_done), 32'(starve_is_ls[i]));
      chk($sformatf("stv_if_done%0d", i), 32'(if_done), 32'(!starve_is_ls[i]));
      if (starve_is_ls[i]) chk($sformatf("stv_ls_rdata%0d", i), ls_rdata, 32'hA0 + 32'(i));
      else                 chk($sformatf("stv_if_data%0d", i), if_data, 32'hA0 + 32'(i));
      tick();
    end
    if_req = 1'b0; ls_req = 1'b0;
    tick();

    // Flush during fetch WAIT: access completes, no done
    if_req = 1'b1; if_addr = 32'h300;
    tick();
    mc_ready = 1'b1;
    tick();
    mc_ready = 1'b0; flush = 1'b1; if_req = 1'b0;
    tick();
    flush = 1'b0; mc_done = 1'b1; mc_rdata = 32'h22222222;
    tick();
    mc_done = 1'b0;
    chk("fl_if_suppressed", 32'(if_done), 32'd0);
    tick();
    chk("fl_if_still_none", 32'(if_done), 32'd0);

    // Flush during store WAIT: store still reports done
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h30000; ls_wdata = 32'h1234;
    tick();
    chk("st_we", 32'(mc_we), 32'd1);
    chk("st_addr", mc_addr, 32'h30000);
    chk("st_wdata", mc_wdata, 32'h1234);
    mc_ready = 1'b1;
    tick();
    mc_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    chk("st_done", 32'(ls_done), 32'd1);
    ls_req = 1'b0; ls_we = 1'b0;
    tick();

    // rdy low mid-ISSUE freezes everything
    ls_req = 1'b1; ls_size = 2'd1; ls_addr = 32'h4002;
    tick();
    rdy = 1'b0; mc_ready = 1'b1; ls_addr = 32'h9999;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("frz_valid%0d", i), 32'(mc_valid), 32'd1);
      chk($sformatf("frz_addr%0d", i), mc_addr, 32'h4002);
      chk($sformatf("frz_size%0d", i), 32'(mc_size), 32'd1);
    end
    rdy = 1'b1;
    tick();
    chk("frz_handshake", 32'(mc_valid), 32'd0);
    mc_ready = 1'b0; mc_done = 1'b1; mc_rdata = 32'h0000BEEF;
    tick();
    mc_done = 1'b0;
    chk("frz_done", 32'(ls_done), 32'd1);
    chk("frz_rdata", ls_rdata, 32'h0000BEEF);
    ls_req = 1'b0;
    tick();
    chk("frz_done_once", 32'(ls_done), 32'd0);

    // Zero-wait controller: ready and done in the same cycle
    if_req = 1'b1; if_addr = 32'h400;
    tick();
    mc_ready = 1'b1; mc_done = 1'b1; mc_rdata = 32'h33333333;
    tick();
    mc_ready = 1'b0; mc_done = 1'b0; if_req = 1'b0;
    chk("zw_done", 32'(if_done), 32'd1);
    chk("zw_data", if_data, 32'h33333333);
    tick();

    // Reset in WAIT; later mc_done ignored
    ls_req = 1'b1; ls_size = 2'd2; ls_addr = 32'h5000;
    tick();
    mc_ready = 1'b1;
    tick();
    mc_ready = 1'b0; rst = 1'b1;
    tick();
    chk("rw_valid", 32'(mc_valid), 32'd0);
    chk("rw_addr", mc_addr, 32'd0);
    chk("rw_ls_rdata", ls_rdata, 32'd0);
    chk("rw_if_data", if_data, 32'd0);
    rst = 1'b0; ls_req = 1'b0; mc_done = 1'b1; mc_rdata = 32'h44444444;
    tick();
    mc_done = 1'b0;
    chk("rw_late_done", 32'(ls_done), 32'd0);
    chk("rw_late_rdata", ls_rdata, 32'd0);

    // Fetch request ignored under flush in IDLE, then served once flush drops
    if_req = 1'b1; if_addr = 32'h500; flush = 1'b1;
    tick();
    chk("idle_flush_ignored", 32'(mc_valid), 32'd0);
    flush = 1'b0;
    tick();
    chk("post_flush_grant", 32'(mc_valid), 32'd1);
    chk("post_flush_addr", mc_addr, 32'h500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
